// File: rtl/kmeans_pkg.sv
// Shared types and helpers for the k-means clustering engine.
// Phase encoding, derived widths and the nearest-centroid selector.
package kmeans_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ACCUM,
    DIVIDE,
    CHECK,
    CLASSIFY,
    DONE
  } phase_t;

  localparam int MAXK  = 16;
  localparam int MAXDW = 64;

  function automatic int dw_f(input int w, input int dims);
    return 2 * w + $clog2(dims);
  endfunction

  function automatic int sw_f(input int w, input int samps);
    return w + $clog2(samps);
  endfunction

  // Strict less-than keeps the lowest index on ties.
  function automatic int argmin(
    input logic [MAXDW-1:0] d [MAXK],
    input int               n
  );
    int best;
    best = 0;
    for (int i = 1; i < MAXK; i++) begin
      if (i < n && d[i] < d[best]) best = i;
    end
    return best;
  endfunction

endpackage

// File: rtl/kmeans_div.sv
// Sequential restoring unsigned divider: one load cycle plus SW steps.
// Quotient/valid are presented combinationally during the final step.
module kmeans_div #(
  parameter int SW = 23,
  parameter int QW = 16
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          start_i,
  input  logic [SW-1:0] dividend_i,
  input  logic [SW-1:0] divisor_i,
  output logic [QW-1:0] quotient_o,
  output logic          valid_o
);

  localparam int CNW = $clog2(SW + 1);
  localparam int RW  = SW + 1;

  logic [RW-1:0]  rem_q, rem_d;
  logic [SW-1:0]  quo_q, quo_d;
  logic [SW-1:0]  dvs_q, dvs_d;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic [SW+1:0]  trial;
  logic           ge;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    trial = {rem_q, quo_q[SW-1]};
    ge    = trial >= {2'b00, dvs_q};
    if (start_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = CNW'(SW);
    end else if (cnt_q != '0) begin
      rem_d = RW'(ge ? trial - {2'b00, dvs_q} : trial);
      quo_d = {quo_q[SW-2:0], ge};
      cnt_d = cnt_q - CNW'(1);
    end
  end

  assign quotient_o = quo_d[QW-1:0];
  assign valid_o    = !start_i && (cnt_q == CNW'(1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/kmeans_engine.sv
// Lloyd-iteration k-means engine: init, accumulate, divide, check,
// then a classify pass streaming one label per sample.
module kmeans_engine
  import kmeans_pkg::*;
#(
  parameter int W         = 16,
  parameter int K         = 3,
  parameter int DIMS      = 6,
  parameter int SAMPS     = 128,
  parameter int MAX_ITERS = 8,
  localparam int AW = (SAMPS > 1) ? $clog2(SAMPS) : 1,
  localparam int KW = (K > 1) ? $clog2(K) : 1,
  localparam int IW = $clog2(MAX_ITERS + 1)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     start_i,
  input  logic [DIMS-1:0][W-1:0]   membus_i,
  output logic [AW-1:0]            addr_o,
  output logic                     busy_o,
  output logic [KW-1:0]            class_o,
  output logic                     class_valid_o,
  output logic                     done_o,
  output logic                     converged_o,
  output logic [IW-1:0]            iters_o
);

  localparam int SW  = sw_f(W, SAMPS);
  localparam int DW  = dw_f(W, DIMS);
  localparam int CW  = $clog2(SAMPS + 1);
  localparam int DMW = (DIMS > 1) ? $clog2(DIMS) : 1;
  localparam logic [AW-1:0] K_LAST = AW'(K - 1);
  localparam logic [AW-1:0] A_LAST = AW'(SAMPS - 1);

  phase_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [W-1:0]    cent_q [K][DIMS];
  logic [W-1:0]    cent_d [K][DIMS];
  logic [SW-1:0]   acc_q [K][DIMS];
  logic [SW-1:0]   acc_d [K][DIMS];
  logic [CW-1:0]   cnt_q [K];
  logic [CW-1:0]   cnt_d [K];
  logic [KW-1:0]   dk_q, dk_d;
  logic [DMW-1:0]  dd_q, dd_d;
  logic            loaded_q, loaded_d;
  logic            changed_q, changed_d;
  logic            conv_q, conv_d;
  logic [IW-1:0]   iters_q, iters_d;

  logic [MAXDW-1:0] dpad [MAXK];
  logic [DW-1:0]    dsum;
  logic [W-1:0]     ad;
  logic [2*W-1:0]   ae;
  logic [KW-1:0]    near;
  logic             div_start, div_valid, last_div;
  logic [W-1:0]     div_quo;

  kmeans_div #(.SW(SW), .QW(W)) u_div (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .start_i    (div_start),
    .dividend_i (acc_q[dk_q][dd_q]),
    .divisor_i  (SW'(cnt_q[dk_q])),
    .quotient_o (div_quo),
    .valid_o    (div_valid)
  );

  // Full-precision squared distance to every centroid.
  always_comb begin
    ad   = '0;
    ae   = '0;
    dsum = '0;
    for (int k = 0; k < MAXK; k++) dpad[k] = '0;
    for (int k = 0; k < K; k++) begin
      dsum = '0;
      for (int d = 0; d < DIMS; d++) begin
        ad = (cent_q[k][d] > membus_i[d]) ?
             cent_q[k][d] - membus_i[d] :
             membus_i[d] - cent_q[k][d];
        ae = (2*W)'(ad);
        dsum = dsum + DW'(ae * ae);
      end
      dpad[k] = MAXDW'(dsum);
    end
    near = KW'(argmin(dpad, K));
  end

  assign last_div = (dk_q == KW'(K - 1)) && (dd_q == DMW'(DIMS - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start_i) state_d = INIT;
      INIT:     if (addr_q == K_LAST) state_d = ACCUM;
      ACCUM:    if (addr_q == A_LAST) state_d = DIVIDE;
      DIVIDE:   if (loaded_q && div_valid && last_div) state_d = CHECK;
      CHECK:    state_d = (!changed_q || iters_q == IW'(MAX_ITERS)) ?
                          CLASSIFY : ACCUM;
      CLASSIFY: if (addr_q == A_LAST) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o        = state_q != IDLE;
    class_valid_o = state_q == CLASSIFY;
    class_o       = class_valid_o ? near : '0;
    done_o        = state_q == DONE;
    addr_o        = addr_q;
    converged_o   = conv_q;
    iters_o       = iters_q;
  end

  always_comb begin
    addr_d    = addr_q;
    cent_d    = cent_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dk_d      = dk_q;
    dd_d      = dd_q;
    loaded_d  = loaded_q;
    changed_d = changed_q;
    conv_d    = conv_q;
    iters_d   = iters_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) begin
        addr_d  = '0;
        iters_d = '0;
        conv_d  = 1'b0;
      end
      INIT: begin
        for (int d = 0; d < DIMS; d++) cent_d[KW'(addr_q)][d] = membus_i[d];
        if (addr_q == K_LAST) begin
          acc_d     = '{default: '0};
          cnt_d     = '{default: '0};
          changed_d = 1'b0;
          addr_d    = '0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      ACCUM: begin
        for (int d = 0; d < DIMS; d++)
          acc_d[near][d] = acc_q[near][d] + SW'(membus_i[d]);
        cnt_d[near] = cnt_q[near] + CW'(1);
        if (addr_q == A_LAST) begin
          addr_d   = '0;
          dk_d     = '0;
          dd_d     = '0;
          loaded_d = 1'b0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      DIVIDE: begin
        if (!loaded_q) begin
          div_start = 1'b1;
          loaded_d  = 1'b1;
        end else if (div_valid) begin
          loaded_d = 1'b0;
          // Empty clusters keep their centroid.
          if (cnt_q[dk_q] != '0) begin
            cent_d[dk_q][dd_q] = div_quo;
            if (div_quo != cent_q[dk_q][dd_q]) changed_d = 1'b1;
          end
          if (last_div) begin
            iters_d = iters_q + IW'(1);
          end else if (dd_q == DMW'(DIMS - 1)) begin
            dd_d = '0;
            dk_d = dk_q + KW'(1);
          end else begin
            dd_d = dd_q + DMW'(1);
          end
        end
      end
      CHECK: begin
        acc_d = '{default: '0};
        cnt_d = '{default: '0};
        if (!changed_q)                       conv_d    = 1'b1;
        else if (iters_q == IW'(MAX_ITERS))   conv_d    = 1'b0;
        else                                  changed_d = 1'b0;
      end
      CLASSIFY: if (addr_q != A_LAST) addr_d = addr_q + AW'(1);
      DONE:     addr_d = '0;
      default:  addr_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q    <= '0;
      cent_q    <= '{default: '0};
      acc_q     <= '{default: '0};
      cnt_q     <= '{default: '0};
      dk_q      <= '0;
      dd_q      <= '0;
      loaded_q  <= 1'b0;
      changed_q <= 1'b0;
      conv_q    <= 1'b0;
      iters_q   <= '0;
    end else begin
      addr_q    <= addr_d;
      cent_q    <= cent_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dk_q      <= dk_d;
      dd_q      <= dd_d;
      loaded_q  <= loaded_d;
      changed_q <= changed_d;
      conv_q    <= conv_d;
      iters_q   <= iters_d;
    end
  end

endmodule

// File: tb/tb_kmeans_engine.sv
// Directed and randomized bench for kmeans_engine against a plain
// arithmetic k-means reference model.
module tb_kmeans_engine;

  localparam int W     = 16;
  localparam int K     = 3;
  localparam int DIMS  = 6;
  localparam int SAMPS = 128;
  localparam int MAXI  = 8;
  localparam int AW    = $clog2(SAMPS);
  localparam int KW    = $clog2(K);
  localparam int IW    = $clog2(MAXI + 1);
  localparam int SWT   = W + $clog2(SAMPS);
  localparam int ITLAT = SAMPS + K * DIMS * (SWT + 1) + 1;
  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  logic rstn, start, sel;
  logic [DIMS-1:0][W-1:0] mem [SAMPS];
  logic [DIMS-1:0][W-1:0] bus0, bus1;
  logic [AW-1:0] addr0, addr1, o_addr;
  logic [KW-1:0] class0, class1, o_class;
  logic busy0, busy1, valid0, valid1, done0, done1, conv0, conv1;
  logic o_busy, o_valid, o_done, o_conv;
  logic [IW-1:0] iters0, o_iters;
  logic          iters1;

  always #5 clk = ~clk;

  assign bus0 = mem[addr0];
  assign bus1 = mem[addr1];

  kmeans_engine #(.W(W), .K(K), .DIMS(DIMS), .SAMPS(SAMPS),
                  .MAX_ITERS(MAXI)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start && !sel),
    .membus_i(bus0), .addr_o(addr0), .busy_o(busy0),
    .class_o(class0), .class_valid_o(valid0), .done_o(done0),
    .converged_o(conv0), .iters_o(iters0)
  );

  kmeans_engine #(.W(W), .K(K), .DIMS(DIMS), .SAMPS(SAMPS),
                  .MAX_ITERS(1)) u_cap (
    .clk_i(clk), .rstn_i(rstn), .start_i(start && sel),
    .membus_i(bus1), .addr_o(addr1), .busy_o(busy1),
    .class_o(class1), .class_valid_o(valid1), .done_o(done1),
    .converged_o(conv1), .iters_o(iters1)
  );

  assign o_addr  = sel ? addr1 : addr0;
  assign o_class = sel ? class1 : class0;
  assign o_busy  = sel ? busy1 : busy0;
  assign o_valid = sel ? valid1 : valid0;
  assign o_done  = sel ? done1 : done0;
  assign o_conv  = sel ? conv1 : conv0;
  assign o_iters = sel ? IW'(iters1) : iters0;

  int errors, checks;
  int exp_lab [SAMPS];
  int exp_iters, exp_lat, last_lat;
  bit exp_conv;
  longint mc [K][DIMS];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int nearest(input int i);
    longint best, dd, df;
    int b;
    b = 0;
    best = 0;
    for (int k = 0; k < K; k++) begin
      dd = 0;
      for (int d = 0; d < DIMS; d++) begin
        df = mc[k][d] - longint'(mem[i][d]);
        dd += df * df;
      end
      if (k == 0 || dd < best) begin
        best = dd;
        b = k;
      end
    end
    return b;
  endfunction

  task automatic model(input int maxi);
    longint s [K][DIMS];
    int n [K];
    bit ch;
    int k;
    longint v;
    for (int kk = 0; kk < K; kk++)
      for (int d = 0; d < DIMS; d++) mc[kk][d] = longint'(mem[kk][d]);
    exp_iters = 0;
    do begin
      for (int kk = 0; kk < K; kk++) begin
        n[kk] = 0;
        for (int d = 0; d < DIMS; d++) s[kk][d] = 0;
      end
      for (int i = 0; i < SAMPS; i++) begin
        k = nearest(i);
        n[k]++;
        for (int d = 0; d < DIMS; d++) s[k][d] += longint'(mem[i][d]);
      end
      ch = 0;
      for (int kk = 0; kk < K; kk++) begin
        if (n[kk] > 0) begin
          for (int d = 0; d < DIMS; d++) begin
            v = s[kk][d] / n[kk];
            if (v != mc[kk][d]) ch = 1;
            mc[kk][d] = v;
          end
        end
      end
      exp_iters++;
    end while (ch && exp_iters < maxi);
    exp_conv = !ch;
    for (int i = 0; i < SAMPS; i++) exp_lab[i] = nearest(i);
    exp_lat = K + exp_iters * ITLAT + SAMPS + 1;
  endtask

  task automatic fill_all(input int v);
    for (int i = 0; i < SAMPS; i++)
      for (int d = 0; d < DIMS; d++) mem[i][d] = W'(v);
  endtask

  task automatic fill_sep();
    int sv [3];
    sv = '{100, 1000, 5000};
    for (int i = 0; i < SAMPS; i++)
      for (int d = 0; d < DIMS; d++) mem[i][d] = W'(sv[i % 3]);
  endtask

  task automatic fill_clusters();
    int ctr [K][DIMS];
    int k;
    for (int kk = 0; kk < K; kk++)
      for (int d = 0; d < DIMS; d++) ctr[kk][d] = int'($urandom_range(1000, 64000));
    for (int i = 0; i < SAMPS; i++) begin
      k = int'($urandom_range(0, K - 1));
      for (int d = 0; d < DIMS; d++)
        mem[i][d] = W'(ctr[k][d] + int'($urandom_range(0, 1000)) - 500);
    end
  endtask

  task automatic fill_uniform();
    for (int i = 0; i < SAMPS; i++)
      for (int d = 0; d < DIMS; d++) mem[i][d] = W'($urandom_range(0, 65535));
  endtask

  task automatic run(input string tag, input int maxi, input bit hold);
    int cyc, seen;
    model(maxi);
    seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = hold;
    cyc = 1;
    while (o_done !== 1'b1 && cyc < LIMIT) begin
      if (o_valid === 1'b1) begin
        chk({tag, "_label"}, 64'(o_class), 64'(exp_lab[o_addr]));
        seen++;
      end
      @(negedge clk);
      cyc++;
    end
    last_lat = cyc;
    chk({tag, "_no_timeout"}, 64'(cyc < LIMIT), 64'(1));
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_labels_seen"}, 64'(seen), 64'(SAMPS));
    chk({tag, "_converged"}, 64'(o_conv), 64'(exp_conv));
    chk({tag, "_iters"}, 64'(o_iters), 64'(exp_iters));
  endtask

  initial begin
    int cyc;
    errors = 0;
    checks = 0;
    rstn = 1'b0;
    start = 1'b0;
    sel = 1'b0;
    fill_all(0);
    repeat (3) @(negedge clk);
    chk("rst_addr", 64'(o_addr), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_class", 64'(o_class), 64'(0));
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_done", 64'(o_done), 64'(0));
    chk("rst_conv", 64'(o_conv), 64'(0));
    chk("rst_iters", 64'(o_iters), 64'(0));
    rstn = 1'b1;

    fill_sep();
    run("sep", MAXI, 1'b0);
    chk("sep_lat693", 64'(last_lat), 64'(693));

    fill_all(7);
    run("same", MAXI, 1'b0);

    for (int i = 0; i < SAMPS; i++)
      for (int d = 0; d < DIMS; d++)
        mem[i][d] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
    run("extreme", MAXI, 1'b0);

    for (int r = 0; r < 3; r++) begin
      fill_clusters();
      run("rand_clu", MAXI, 1'b0);
    end
    fill_uniform();
    run("rand_uni", MAXI, 1'b0);

    sel = 1'b1;
    fill_all(1000);
    for (int d = 0; d < DIMS; d++) begin
      mem[0][d] = 16'd0;
      mem[1][d] = 16'd10;
      mem[2][d] = 16'd20;
    end
    run("cap", 1, 1'b0);
    sel = 1'b0;

    // Asynchronous reset in the middle of accumulation.
    fill_sep();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    chk("pre_rst_addr", 64'(o_addr), 64'(46));
    chk("pre_rst_busy", 64'(o_busy), 64'(1));
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(o_busy), 64'(0));
    chk("mid_rst_addr", 64'(o_addr), 64'(0));
    chk("mid_rst_valid", 64'(o_valid), 64'(0));
    chk("mid_rst_iters", 64'(o_iters), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    run("rerun", MAXI, 1'b0);

    // start held high across a whole run and into the next.
    run("held", MAXI, 1'b1);
    @(negedge clk);
    chk("held_idle_busy", 64'(o_busy), 64'(0));
    chk("held_idle_conv", 64'(o_conv), 64'(exp_conv));
    chk("held_idle_iters", 64'(o_iters), 64'(exp_iters));
    @(negedge clk);
    chk("held_restart_busy", 64'(o_busy), 64'(1));
    chk("held_restart_conv", 64'(o_conv), 64'(0));
    chk("held_restart_iters", 64'(o_iters), 64'(0));
    start = 1'b0;
    cyc = 0;
    while (o_done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    chk("held2_no_timeout", 64'(cyc < LIMIT), 64'(1));
    chk("held2_converged", 64'(o_conv), 64'(exp_conv));
    chk("held2_iters", 64'(o_iters), 64'(exp_iters));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
